// File: rtl/cla_pkg.sv
// Shared types and the flat carry-lookahead equation used by every adder group.
package cla_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Widest group the lookahead helper can handle; narrower groups are zero-extended.
    localparam int CLA_MAXG = 16;

    // Carry into bit n of a group, written as a flat sum of generate/propagate products:
    // c[n] = cin & p[0..n-1]  |  OR_j ( g[j] & p[j+1..n-1] ),  j < n.
    function automatic logic cla_carry(
        input logic [CLA_MAXG-1:0] g,
        input logic [CLA_MAXG-1:0] p,
        input logic                cin,
        input int                  n
    );
        logic c;
        logic term;
        c = cin;
        for (int k = 0; k < CLA_MAXG; k++) begin
            if (k < n) c = c & p[k];
        end
        for (int j = 0; j < CLA_MAXG; j++) begin
            term = g[j] & (j < n);
            for (int k = j + 1; k < CLA_MAXG; k++) begin
                if (k < n) term = term & p[k];
            end
            c = c | term;
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_group_slice.sv
// One combinational lookahead group: per-bit sums from flat carries plus group generate/propagate.
module cla_group_slice
    import cla_pkg::*;
#(
    parameter int GROUP = 4
)
(
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             cin_i,
    output logic [GROUP-1:0] sum_o,
    output logic             g_o,
    output logic             p_o
);

    logic [CLA_MAXG-1:0] g_ext;
    logic [CLA_MAXG-1:0] p_ext;

    if (GROUP < 1 || GROUP > CLA_MAXG) begin : g_chk_group
        $error("cla_group_slice: GROUP out of range");
    end

    assign g_ext = CLA_MAXG'(a_i & b_i);
    assign p_ext = CLA_MAXG'(a_i ^ b_i);

    // Group generate/propagate do not depend on cin, so the group-level chain stays acyclic.
    assign g_o = cla_carry(g_ext, p_ext, 1'b0, GROUP);
    assign p_o = &p_ext[GROUP-1:0];

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < GROUP; i++) begin
            sum_o[i] = p_ext[i] ^ cla_carry(g_ext, p_ext, cin_i, i);
        end
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor; each stage resolves GPS groups and rippling
// group carries, with a valid/ready chain that accepts a beat whenever the pipe can move.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NG   = WIDTH / GROUP;
    localparam int GPS  = NG / STAGES;
    localparam int NFWD = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH % GROUP != 0) begin : g_chk_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end
    if (STAGES < 1 || NG % STAGES != 0) begin : g_chk_stages
        $error("pipelined_cla_adder: WIDTH/GROUP must be a multiple of STAGES");
    end

    // Stage registers; a/b are only forwarded into stages that still have groups to resolve.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [WIDTH-1:0]  a_q   [NFWD];
    logic [WIDTH-1:0]  b_q   [NFWD];
    logic              ovf_q;

    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_s   [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];
    logic [WIDTH-1:0]  s_d     [STAGES];
    logic [STAGES-1:0] c_d;
    logic              ovf_d;

    logic [GROUP-1:0]  grp_sum [NG];
    logic [NG-1:0]     grp_g;
    logic [NG-1:0]     grp_p;
    logic [NG-1:0]     grp_cin;
    logic [NG-1:0]     grp_cout;
    logic              carry_run;

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_first
            assign src_v[0]   = in_valid;
            assign src_a[0]   = in_a;
            assign src_b[0]   = (op_e'(in_op) == OP_SUB) ? ~in_b : in_b;
            assign src_c[0]   = (op_e'(in_op) == OP_SUB) ? 1'b1 : in_cin;
            assign src_s[0]   = '0;
            assign src_tag[0] = in_tag;
        end else begin : g_next
            assign src_v[k]   = v_q[k-1];
            assign src_a[k]   = a_q[k-1];
            assign src_b[k]   = b_q[k-1];
            assign src_c[k]   = c_q[k-1];
            assign src_s[k]   = s_q[k-1];
            assign src_tag[k] = tag_q[k-1];
        end
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        localparam int ST = gi / GPS;
        cla_group_slice #(.GROUP(GROUP)) u_slice (
            .a_i   (src_a[ST][gi*GROUP +: GROUP]),
            .b_i   (src_b[ST][gi*GROUP +: GROUP]),
            .cin_i (grp_cin[gi]),
            .sum_o (grp_sum[gi]),
            .g_o   (grp_g[gi]),
            .p_o   (grp_p[gi])
        );
    end

    // Group carries ripple inside a stage and restart from the stage's registered carry.
    always_comb begin
        carry_run = 1'b0;
        grp_cin   = '0;
        grp_cout  = '0;
        for (int gi = 0; gi < NG; gi++) begin
            if (gi % GPS == 0) carry_run = src_c[gi / GPS];
            grp_cin[gi]  = carry_run;
            carry_run    = grp_g[gi] | (grp_p[gi] & carry_run);
            grp_cout[gi] = carry_run;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = src_s[k];
            for (int j = 0; j < GPS; j++) begin
                s_d[k][(k*GPS + j)*GROUP +: GROUP] = grp_sum[k*GPS + j];
            end
            c_d[k] = grp_cout[(k+1)*GPS - 1];
        end
        // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
        ovf_d = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
              ^ s_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
    end

    always_comb begin
        ld = '0;
        ld[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld[k] = !v_q[k] || ld[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k]   <= '0;
                tag_q[k] <= '0;
            end
            for (int k = 0; k < NFWD; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) v_q[k] <= src_v[k];
                if (ld[k] && src_v[k]) begin
                    s_q[k]   <= s_d[k];
                    c_q[k]   <= c_d[k];
                    tag_q[k] <= src_tag[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (ld[k] && src_v[k]) begin
                    a_q[k] <= src_a[k];
                    b_q[k] <= src_b[k];
                end
            end
            if (ld[STAGES-1] && src_v[STAGES-1]) ovf_q <= ovf_d;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q;
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed table plus streaming, backpressure and mid-stream reset sequences for the pipelined adder.
module tb_pipelined_cla_adder;

    localparam int W = 32;
    localparam int S = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_op;
    logic [3:0]    in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic [3:0]    out_tag;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4), .STAGES(S), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        op;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    int    accepted;
    int    popped;
    logic  prev_stall;
    exp_t  held;
    exp_t  sbq[$];
    vec_t  tab[12];
    logic [31:0] sa[16];
    logic [31:0] sb[16];
    logic        scin[16];
    logic        sop[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic op, input logic [3:0] tag);
        exp_t        e;
        logic [31:0] bb;
        logic        c;
        logic [32:0] r;
        bb = op ? ~b : b;
        c  = op ? 1'b1 : cin;
        r  = {1'b0, a} + {1'b0, bb} + {32'd0, c};
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = (a[31] == bb[31]) && (r[31] != a[31]);
        e.tag  = tag;
        return e;
    endfunction

    // Called at the negative edge: scoreboard pop, stall stability, and push of the beat about to be accepted.
    task automatic cycle_check();
        exp_t e;
        if (prev_stall) begin
            chk("stall_valid_hold", {63'd0, out_valid}, 64'd1);
            chk("stall_data_hold", {26'd0, out_sum, out_cout, out_ovf, out_tag}, {26'd0, held});
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sbq.pop_front();
                popped++;
                chk("stream_sum", {32'd0, out_sum}, {32'd0, e.sum});
                chk("stream_cout", {63'd0, out_cout}, {63'd0, e.cout});
                chk("stream_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
                chk("stream_tag", {60'd0, out_tag}, {60'd0, e.tag});
            end
        end
        prev_stall = out_valid && !out_ready;
        held = {out_sum, out_cout, out_ovf, out_tag};
        if (in_valid && in_ready) begin
            sbq.push_back(model(in_a, in_b, in_cin, in_op, in_tag));
            accepted++;
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [3:0] tag);
        int lat;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        in_op     = v.op;
        in_tag    = tag;
        out_ready = 1'b1;
        #1 chk("vec_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("vec_latency", lat, S);
        chk("vec_sum", {32'd0, out_sum}, {32'd0, v.sum});
        chk("vec_cout", {63'd0, out_cout}, {63'd0, v.cout});
        chk("vec_ovf", {63'd0, out_ovf}, {63'd0, v.ovf});
        chk("vec_tag", {60'd0, out_tag}, {60'd0, tag});
    endtask

    task automatic drive_beat(input int idx);
        in_a   = sa[idx];
        in_b   = sb[idx];
        in_cin = scin[idx];
        in_op  = sop[idx];
        in_tag = 4'(idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          a             b             cin   op    sum           cout  ovf
        tab[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tab[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tab[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tab[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tab[4]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};
        tab[5]  = '{32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tab[6]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        tab[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tab[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        tab[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tab[10] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tab[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            sa[i]   = $urandom;
            sb[i]   = $urandom;
            scin[i] = 1'($urandom_range(0, 1));
            sop[i]  = 1'($urandom_range(0, 1));
        end

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_op = 1'b0; in_tag = '0;
        prev_stall = 1'b0; accepted = 0; popped = 0; held = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data", {26'd0, out_sum, out_cout, out_ovf, out_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 12; i++) run_vec(tab[i], 4'(i));

        // Streaming with random downstream readiness.
        accepted = 0; popped = 0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 400 && (accepted < 16 || sbq.size() != 0); cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (accepted < 16) begin
                in_valid = 1'b1;
                drive_beat(accepted);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cycle_check();
        end
        in_valid = 1'b0;
        chk("stream_count", popped, 16);

        // Ten stalled cycles with continuous input, then release.
        accepted = 0; popped = 0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            drive_beat(accepted);
            @(negedge clk);
            cycle_check();
        end
        chk("bp_accepts", accepted, S);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive_beat(accepted);
        #1 chk("bp_in_ready_resume", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        cycle_check();
        for (int cyc = 0; cyc < 20 && (accepted < 4 || sbq.size() != 0); cyc++) begin
            @(posedge clk); #1;
            in_valid = (accepted < 4);
            if (accepted < 4) drive_beat(accepted);
            @(negedge clk);
            cycle_check();
        end
        in_valid = 1'b0;
        chk("bp_count", popped, 4);

        // Fill the pipe, then reset asynchronously mid-cycle.
        accepted = 0; popped = 0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            drive_beat(accepted + 8);
            @(negedge clk);
            cycle_check();
        end
        chk("rst_pipe_full", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_async_data", {26'd0, out_sum, out_cout, out_ovf, out_tag}, 64'd0);
        in_valid = 1'b0;
        sbq.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("rst_release_in_ready", {63'd0, in_ready}, 64'd1);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            chk("rst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        run_vec(tab[1], 4'hA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
